// File: rtl/rom_port_arbiter.sv
// Shares the 4-bank program ROM between instruction fetch (3-byte window) and MOVC (1 byte).
// Latency: data valid 2 cycles after the accept edge; acks are combinational, one grant per cycle, no bubbles.
module rom_port_arbiter #(
    parameter bit FAIR = 1'b1,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_pc,
    output logic          if_ack,
    input  logic          if_flush,
    output logic          if_valid,
    output logic [7:0]    if_data1,
    output logic [7:0]    if_data2,
    output logic [7:0]    if_data3,

    input  logic          mv_req,
    input  logic [AW-1:0] mv_addr,
    output logic          mv_ack,
    output logic          mv_valid,
    output logic [7:0]    mv_data,

    output logic [AW-3:0] rom_addr0,
    output logic [AW-3:0] rom_addr1,
    output logic [AW-3:0] rom_addr2,
    output logic [AW-3:0] rom_addr3,
    input  logic [7:0]    rom_data0,
    input  logic [7:0]    rom_data1,
    input  logic [7:0]    rom_data2,
    input  logic [7:0]    rom_data3
);
    localparam int WW = AW - 2;

    typedef enum logic {OWN_IF = 1'b0, OWN_MV = 1'b1} own_e;

    typedef struct packed {
        logic       vld;
        own_e       own;
        logic [1:0] s;
    } tag_t;

    logic          pref_mv;
    logic          accept;
    logic [AW-1:0] acc_addr;
    logic [WW-1:0] w;
    logic [WW-1:0] wt;
    logic [1:0]    s;
    logic [WW-1:0] addr_nxt [4];
    tag_t          tag_a;
    tag_t          tag_b;
    tag_t          tag_a_nxt;
    tag_t          tag_b_nxt;
    logic          fire_if;
    logic          fire_mv;
    logic [7:0]    bank [4];

    assign bank[0] = rom_data0;
    assign bank[1] = rom_data1;
    assign bank[2] = rom_data2;
    assign bank[3] = rom_data3;

    // pref_mv low means fetch wins the next conflict
    always_comb begin
        if_ack = 1'b0;
        mv_ack = 1'b0;
        if (!rst) begin
            if (if_req && mv_req) begin
                if (FAIR && pref_mv)
                    mv_ack = 1'b1;
                else
                    if_ack = 1'b1;
            end else begin
                if_ack = if_req;
                mv_ack = mv_req;
            end
        end
    end

    assign accept   = if_ack | mv_ack;
    assign acc_addr = if_ack ? if_pc : mv_addr;
    assign w        = acc_addr[AW-1:2];
    assign s        = acc_addr[1:0];
    assign wt       = w + WW'(1);

    // Banks below the start lane belong to the next word for an unaligned fetch window
    always_comb begin
        for (int b = 0; b < 4; b++)
            addr_nxt[b] = w;
        if (if_ack) begin
            addr_nxt[0] = (s == 2'd0) ? w : wt;
            addr_nxt[1] = (s <= 2'd1) ? w : wt;
            addr_nxt[2] = (s == 2'd3) ? wt : w;
        end
    end

    always_comb begin
        tag_a_nxt = '0;
        if (accept) begin
            tag_a_nxt.vld = 1'b1;
            tag_a_nxt.own = mv_ack ? OWN_MV : OWN_IF;
            tag_a_nxt.s   = s;
        end
        tag_b_nxt = tag_a;
        if (if_flush && tag_a.own == OWN_IF)
            tag_b_nxt.vld = 1'b0;
    end

    // A flush on the edge that would deliver a fetch also drops that fetch
    assign fire_if = tag_b.vld && (tag_b.own == OWN_IF) && !if_flush;
    assign fire_mv = tag_b.vld && (tag_b.own == OWN_MV);

    always_ff @(posedge clk) begin
        if (rst) begin
            pref_mv   <= 1'b0;
            tag_a     <= '0;
            tag_b     <= '0;
            rom_addr0 <= '0;
            rom_addr1 <= '0;
            rom_addr2 <= '0;
            rom_addr3 <= '0;
            if_valid  <= 1'b0;
            mv_valid  <= 1'b0;
            if_data1  <= '0;
            if_data2  <= '0;
            if_data3  <= '0;
            mv_data   <= '0;
        end else begin
            if (accept) begin
                pref_mv   <= if_ack;
                rom_addr0 <= addr_nxt[0];
                rom_addr1 <= addr_nxt[1];
                rom_addr2 <= addr_nxt[2];
                rom_addr3 <= addr_nxt[3];
            end
            tag_a    <= tag_a_nxt;
            tag_b    <= tag_b_nxt;
            if_valid <= fire_if;
            mv_valid <= fire_mv;
            if (fire_if) begin
                if_data1 <= bank[tag_b.s];
                if_data2 <= bank[tag_b.s + 2'd1];
                if_data3 <= bank[tag_b.s + 2'd2];
            end
            if (fire_mv)
                mv_data <= bank[tag_b.s];
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: byte-level reference model with a pending-read queue, directed cases then random traffic.
module tb_rom_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, mv_req = 1'b0;
    logic [15:0] if_pc = '0, mv_addr = '0;
    logic        if_ack, if_valid, mv_ack, mv_valid;
    logic [7:0]  if_data1, if_data2, if_data3, mv_data;
    logic [13:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3;
    logic [7:0]  rom_data0, rom_data1, rom_data2, rom_data3;

    logic        z_rst = 1'b1;
    logic        z_if_req = 1'b0, z_mv_req = 1'b0, z_flush = 1'b0;
    logic [15:0] z_pc = '0, z_ma = '0;
    logic        z_if_ack, z_if_valid, z_mv_ack, z_mv_valid;
    logic [7:0]  z_d1, z_d2, z_d3, z_md;
    logic [13:0] z_ra0, z_ra1, z_ra2, z_ra3;
    logic [7:0]  z_rd = 8'h00;

    rom_port_arbiter #(.FAIR(1'b1), .AW(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_flush(if_flush),
        .if_valid(if_valid), .if_data1(if_data1), .if_data2(if_data2), .if_data3(if_data3),
        .mv_req(mv_req), .mv_addr(mv_addr), .mv_ack(mv_ack), .mv_valid(mv_valid), .mv_data(mv_data),
        .rom_addr0(rom_addr0), .rom_addr1(rom_addr1), .rom_addr2(rom_addr2), .rom_addr3(rom_addr3),
        .rom_data0(rom_data0), .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3)
    );

    rom_port_arbiter #(.FAIR(1'b0), .AW(16)) dut_fixed (
        .clk(clk), .rst(z_rst),
        .if_req(z_if_req), .if_pc(z_pc), .if_ack(z_if_ack), .if_flush(z_flush),
        .if_valid(z_if_valid), .if_data1(z_d1), .if_data2(z_d2), .if_data3(z_d3),
        .mv_req(z_mv_req), .mv_addr(z_ma), .mv_ack(z_mv_ack), .mv_valid(z_mv_valid), .mv_data(z_md),
        .rom_addr0(z_ra0), .rom_addr1(z_ra1), .rom_addr2(z_ra2), .rom_addr3(z_ra3),
        .rom_data0(z_rd), .rom_data1(z_rd), .rom_data2(z_rd), .rom_data3(z_rd)
    );

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] + 8'(a[15:8] * 8'd37);
    endfunction

    // Program ROM: each bank registers the byte at {word, bank}
    always @(posedge clk) begin
        rom_data0 <= rom_byte({rom_addr0, 2'd0});
        rom_data1 <= rom_byte({rom_addr1, 2'd1});
        rom_data2 <= rom_byte({rom_addr2, 2'd2});
        rom_data3 <= rom_byte({rom_addr3, 2'd3});
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          mv;
        logic [15:0] a;
        int          due;
        bit          dead;
    } ent_t;

    ent_t        pend[$];
    bit          pref_mv = 1'b0;
    int          cyc = 0;
    logic        exp_ifv = 1'b0, exp_mvv = 1'b0;
    logic [7:0]  e_d1 = '0, e_d2 = '0, e_d3 = '0, e_md = '0;
    logic [13:0] e_ra [4] = '{default: '0};
    int          n_ifv = 0, n_mvv = 0;
    logic        obs_ifack, obs_mvack;

    // One clock: check the last edge's results, drive inputs, check grants, advance the model across the edge
    task automatic one_cycle(input logic r, input logic ir, input logic [15:0] pc,
                             input logic mr, input logic [15:0] ma, input logic fl,
                             output logic gi, output logic gm);
        ent_t        e;
        logic [13:0] w, wt;
        logic [1:0]  s;
        @(negedge clk);
        check("if_valid", if_valid, exp_ifv);
        check("mv_valid", mv_valid, exp_mvv);
        check("if_data1", if_data1, e_d1);
        check("if_data2", if_data2, e_d2);
        check("if_data3", if_data3, e_d3);
        check("mv_data", mv_data, e_md);
        check("rom_addr0", rom_addr0, e_ra[0]);
        check("rom_addr1", rom_addr1, e_ra[1]);
        check("rom_addr2", rom_addr2, e_ra[2]);
        check("rom_addr3", rom_addr3, e_ra[3]);
        if (if_valid === 1'b1) n_ifv++;
        if (mv_valid === 1'b1) n_mvv++;
        rst = r; if_req = ir; if_pc = pc; mv_req = mr; mv_addr = ma; if_flush = fl;
        #1;
        gi = !r && ir && (!mr || !pref_mv);
        gm = !r && mr && !gi;
        obs_ifack = if_ack;
        obs_mvack = mv_ack;
        check("if_ack", if_ack, gi);
        check("mv_ack", mv_ack, gm);
        @(posedge clk);
        if (r) begin
            pend.delete();
            exp_ifv = 0; exp_mvv = 0;
            e_d1 = '0; e_d2 = '0; e_d3 = '0; e_md = '0;
            e_ra = '{default: '0};
            pref_mv = 1'b0;
        end else begin
            if (fl)
                foreach (pend[i]) if (!pend[i].mv) pend[i].dead = 1'b1;
            exp_ifv = 0; exp_mvv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                if (!e.dead) begin
                    if (e.mv) begin
                        exp_mvv = 1; e_md = rom_byte(e.a);
                    end else begin
                        exp_ifv = 1;
                        e_d1 = rom_byte(e.a);
                        e_d2 = rom_byte(e.a + 16'd1);
                        e_d3 = rom_byte(e.a + 16'd2);
                    end
                end
            end
            if (gi) begin
                pend.push_back('{mv: 1'b0, a: pc, due: cyc + 2, dead: 1'b0});
                w = pc[15:2]; s = pc[1:0]; wt = w + 14'd1;
                e_ra[0] = (s == 0) ? w : wt;
                e_ra[1] = (s <= 1) ? w : wt;
                e_ra[2] = (s == 3) ? wt : w;
                e_ra[3] = w;
                pref_mv = 1'b1;
            end else if (gm) begin
                pend.push_back('{mv: 1'b1, a: ma, due: cyc + 2, dead: 1'b0});
                for (int b = 0; b < 4; b++) e_ra[b] = ma[15:2];
                pref_mv = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a, b;
        repeat (n) one_cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic        gi, gm, pi, pm, r, fl;
        logic [15:0] pc, ma;
        int          n0, zc;

        repeat (2) @(posedge clk);

        // Fetch-always-wins variant: four conflicting cycles give four fetch grants
        zc = 0;
        @(negedge clk) z_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (z_if_valid === 1'b1) zc++;
            check("f0_mv_valid", z_mv_valid, 0);
            z_if_req = (k < 4); z_mv_req = (k < 4);
            z_pc = 16'(k * 4); z_ma = 16'h0200;
            #1;
            check("f0_if_ack", z_if_ack, (k < 4));
            check("f0_mv_ack", z_mv_ack, 0);
        end
        check("f0_valid_count", zc, 4);

        // Reset state, and requests under reset get no grant
        one_cycle(1'b1, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, gi, gm);
        check("rst_no_if_ack", obs_ifack, 0);
        check("rst_no_mv_ack", obs_mvack, 0);

        // Single fetch at an unaligned pc
        one_cycle(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0, 1'b0, gi, gm);
        check("single_ack", obs_ifack, 1);
        one_cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, gi, gm);
        check("single_ra0", rom_addr0, 14'h0002);
        check("single_ra1", rom_addr1, 14'h0001);
        idle(2);
        check("single_d1", if_data1, 8'h05);
        check("single_d3", if_data3, 8'h07);

        // Window wrapping past the top of code space
        one_cycle(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0, gi, gm);
        idle(3);
        check("wrap_ra2", rom_addr2, 14'h3FFF);
        check("wrap_ra0", rom_addr0, 14'h0000);
        check("wrap_d3", if_data3, rom_byte(16'h0000));

        // Contention from fetch-preferred state alternates F,M,F,M
        one_cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, gi, gm);
        pc = 16'h0300; ma = 16'h0401;
        for (int k = 0; k < 4; k++) begin
            one_cycle(1'b0, 1'b1, pc, 1'b1, ma, 1'b0, gi, gm);
            check("contend_if_ack", obs_ifack, (k % 2 == 0));
            check("contend_mv_ack", obs_mvack, (k % 2 == 1));
            if (gi) pc = pc + 16'd3;
            if (gm) ma = ma + 16'd1;
        end
        idle(3);

        // MOVC then fetch back to back
        n0 = n_mvv;
        one_cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h1236, 1'b0, gi, gm);
        one_cycle(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0, gi, gm);
        idle(3);
        check("movc_data", mv_data, rom_byte(16'h1236));
        check("movc_pulses", n_mvv - n0, 1);
        check("movc_then_fetch_d1", if_data1, rom_byte(16'h0100));

        // Flush drops the older fetch, keeps the one accepted on the flush edge
        n0 = n_ifv;
        one_cycle(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, gi, gm);
        one_cycle(1'b0, 1'b1, 16'h0081, 1'b0, 16'h0, 1'b1, gi, gm);
        idle(3);
        check("flush_pulses", n_ifv - n0, 1);
        check("flush_d1", if_data1, rom_byte(16'h0081));

        // Reset mid-flight kills the read
        one_cycle(1'b0, 1'b1, 16'h0123, 1'b0, 16'h0, 1'b0, gi, gm);
        n0 = n_ifv;
        one_cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, gi, gm);
        idle(3);
        check("rst_mid_pulses", n_ifv - n0, 0);
        check("rst_mid_ra0", rom_addr0, 0);
        check("rst_mid_d1", if_data1, 0);

        // Random traffic: requests held until granted
        pi = 1'b0; pm = 1'b0; pc = '0; ma = '0;
        for (int k = 0; k < 2000; k++) begin
            if (!pi && ($urandom % 3 != 0)) begin
                pi = 1'b1;
                pc = ($urandom % 4 == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            end
            if (!pm && ($urandom % 3 == 0)) begin
                pm = 1'b1;
                ma = ($urandom % 4 == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            end
            r  = ($urandom % 150 == 0);
            fl = ($urandom % 12 == 0);
            one_cycle(r, pi, pc, pm, ma, fl, gi, gm);
            if (gi) pi = 1'b0;
            if (gm) pm = 1'b0;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the 4-bank, 32-bit-wide program ROM between two requesters: instruction fetch (3-byte opcode window at PC) and MOVC code-space reads (1 byte).
- Arbitrates per cycle and drives the four 14-bit bank addresses, including the +1 word carry for unaligned windows.
- Tracks in-flight reads through a 2-stage tag pipeline and steers rotated bank data back to the owner.
- Sits between the CPU core and the program ROM.

Parameters:
- FAIR, 1, 1 = round-robin on conflict; 0 = fetch always wins.
- AW, 16, code address width; bank word address is AW-2 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until accepted
- if_pc  in  16  fetch byte address
- if_ack  out  1  combinational grant; transfer occurs at the edge where if_req && if_ack
- if_flush  in  1  discard all fetch reads in flight
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_data1, if_data2, if_data3  out  8 each  bytes at pc, pc+1, pc+2
- mv_req  in  1  MOVC request; held until accepted
- mv_addr  in  16  MOVC byte address
- mv_ack  out  1  combinational grant
- mv_valid  out  1  MOVC data valid, one-cycle pulse
- mv_data  out  8  byte at mv_addr
- rom_addr0 .. rom_addr3  out  14 each  bank word addresses, registered
- rom_data0 .. rom_data3  in  8 each  bank read data, registered inside the ROM (1-cycle latency)

Behaviour:
- Reset outputs: rom_addr* = 0; if_valid = mv_valid = 0; all data outputs = 0; both tag stages invalid; rr pointer = fetch-preferred. Reset mid-operation kills all in-flight reads; no valid pulses afterwards.
- Arbitration, combinational:
  - Only one requesting: it gets ack.
  - Both requesting, FAIR=1: grant the side not granted last. FAIR=0: grant fetch.
  - rr pointer updates only on an accepted transfer.
  - At most one ack per cycle.
- Address generation at the accept edge T. Let w = addr[15:2], s = addr[1:0], wt = w+1 (14-bit, 0x3FFF wraps to 0x0000).
  - Fetch:
    - rom_addr0 = (s==0) ? w : wt
    - rom_addr1 = (s<=1) ? w : wt
    - rom_addr2 = (s==3) ? wt : w
    - rom_addr3 = w
  - MOVC: all four banks driven with w.
  - No accept: rom_addr* hold their values.
- Tag pipeline:
  - Stage A is loaded at T with {valid, owner, s}.
  - Stage B is loaded at T+1 from stage A.
  - ROM data is valid while stage B is valid.
  - Outputs are registered at edge T+2: the valid pulse is high for exactly the one cycle after T+2.
  - Throughput is one accept per cycle, with no bubbles, for any request mix.
- Fetch steering, using stage B's s. Lanes rotate so data1 = bank s, data2 = bank (s+1) mod 4, data3 = bank (s+2) mod 4:
  - s=0: data1/2/3 = banks 0/1/2
  - s=1: banks 1/2/3
  - s=2: banks 2/3/0
  - s=3: banks 3/0/1
- MOVC steering: mv_data = bank s.
- Data outputs hold their last value when valid is low.
- Flush:
  - if_flush at an edge clears the fetch-owned entries in stages A and B that existed before that edge.
  - A fetch accepted at the same edge is kept.
  - MOVC entries are unaffected.
  - Flush does not block acceptance.
- Requests while rst is high: no ack.

Test Plan:
- Single fetch, pc=0x0005, ROM bytes = address LSB → if_ack in the request cycle; rom_addr0=0x0002, rom_addr1..3=0x0001; if_valid two cycles after the accept edge with data1/2/3 = 0x05/0x06/0x07.
- Wrap: fetch pc=0xFFFE → rom_addr0=rom_addr1=0x0000, rom_addr2=rom_addr3=0x3FFF; data = bytes at 0xFFFE, 0xFFFF, 0x0000.
- Contention, FAIR=1, both req held for 4 cycles → acks alternate F,M,F,M; valids follow two cycles later in the same order, one per cycle. With FAIR=0 → four fetch acks, no mv_ack.
- MOVC mv_addr=0x1236 back-to-back with fetch pc=0x0100 → mv_valid with mv_data=bank2 byte, then if_valid the next cycle; no lane cross-talk.
- Flush: fetches accepted at T and T+1, if_flush at T+1 edge together with a new fetch at T+1 → only the T+1 fetch returns if_valid; the T fetch never pulses.
- Reset mid-flight: accept at T, rst at T+1 → no if_valid at T+2; all outputs and rom_addr* = 0.
